// File: rtl/relu_func.sv
// ReLU activation for a truncated neuron MAC sum: a constant lookup table
// indexed by the top MEM_WIDTH bits of the sum, followed by one output register.
module relu_func #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int MEM_WIDTH     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEM_WIDTH-1:0]         in,
    output logic [2*IP_DATA_WIDTH-1:0]   mem_out
);

    localparam int OUT_W = 2 * IP_DATA_WIDTH;
    localparam int DEPTH = 2 ** MEM_WIDTH;
    localparam int SHIFT = OUT_W - MEM_WIDTH;

    if (MEM_WIDTH < 2 || MEM_WIDTH > OUT_W) begin : g_bad_width
        $error("relu_func: MEM_WIDTH must lie in [2, 2*IP_DATA_WIDTH]");
    end

    typedef logic [OUT_W-1:0] lut_t [DEPTH];

    // Negative codes clamp to zero; positive codes are shifted back up to
    // the magnitude they had before truncation, so the MSB is always clear.
    function automatic lut_t build_lut();
        lut_t                 t;
        logic [MEM_WIDTH-1:0] addr;
        for (int a = 0; a < DEPTH; a++) begin
            addr = MEM_WIDTH'(a);
            if (addr[MEM_WIDTH-1])
                t[a] = '0;
            else
                t[a] = OUT_W'(addr) << SHIFT;
        end
        return t;
    endfunction

    localparam lut_t RELU_LUT = build_lut();

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_out <= '0;
        else
            mem_out <= RELU_LUT[in];
    end

endmodule

// File: tb/tb_relu_func.sv
// Scoreboard bench for relu_func: stimulus pushes reference results into a
// queue, a monitor pops one per rising edge and compares.
module tb_relu_func;

    localparam int IP_DATA_WIDTH = 8;
    localparam int MEM_WIDTH     = 5;
    localparam int OUT_W         = 2 * IP_DATA_WIDTH;
    localparam int SHIFT         = OUT_W - MEM_WIDTH;

    logic                 clk;
    logic                 rst;
    logic [MEM_WIDTH-1:0] in_sig;
    logic [OUT_W-1:0]     mem_out;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] exp_q [$];

    relu_func #(
        .IP_DATA_WIDTH(IP_DATA_WIDTH),
        .MEM_WIDTH    (MEM_WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_sig),
        .mem_out(mem_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: read the code as a signed integer, clamp negatives, rescale.
    function automatic logic [OUT_W-1:0] relu_model(input int code);
        int v;
        v = (code >= (1 << (MEM_WIDTH - 1))) ? code - (1 << MEM_WIDTH) : code;
        if (v < 0)
            return '0;
        return OUT_W'(v * (1 << SHIFT));
    endfunction

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual,
                               input logic [OUT_W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int code);
        @(negedge clk);
        in_sig = MEM_WIDTH'(code);
        exp_q.push_back(relu_model(code));
    endtask

    task automatic waitDrain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        // let the monitor finish its hold check on the last item
        @(negedge clk);
        #4;
    endtask

    // Monitor: each rising edge with an outstanding item loads that item;
    // it must still be held after the following falling edge.
    initial begin
        logic [OUT_W-1:0] e;
        forever begin
            @(posedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                checkOutput("load", mem_out, e);
                @(negedge clk);
                #2;
                checkOutput("hold", mem_out, e);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        in_sig = '0;
        #2 rst = 1'b0;
        #1 checkOutput("reset_state", mem_out, 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", mem_out, 16'h0000);
        #1 rst = 1'b1;

        applyStimulus(5'b00011);
        waitDrain();
        checkOutput("pos_3", mem_out, 16'h1800);

        applyStimulus(5'b01111);
        applyStimulus(5'b10000);
        applyStimulus(5'b11111);
        applyStimulus(0);
        waitDrain();

        applyStimulus(1);
        applyStimulus(2);
        applyStimulus(0);
        applyStimulus(31);
        waitDrain();

        for (int c = 0; c < (1 << MEM_WIDTH); c++)
            applyStimulus(c);
        waitDrain();

        for (int i = 0; i < 200; i++)
            applyStimulus(int'($urandom_range((1 << MEM_WIDTH) - 1, 0)));
        waitDrain();

        // Async reset from the most-positive output, between clock edges
        applyStimulus(5'b01111);
        waitDrain();
        checkOutput("pre_reset", mem_out, 16'h7800);
        rst = 1'b0;
        #1 checkOutput("async_clear", mem_out, 16'h0000);
        in_sig = 'x;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 checkOutput("reset_low_hold", mem_out, 16'h0000);
        end

        @(negedge clk);
        rst    = 1'b1;
        in_sig = 5'b00100;
        exp_q.push_back(relu_model(5'b00100));
        #1 checkOutput("release_no_stale", mem_out, 16'h0000);
        waitDrain();
        checkOutput("release_first", mem_out, 16'h2000);

        // Mid-stream reset: an input is presented but reset lands before its edge
        applyStimulus(7);
        waitDrain();
        @(negedge clk);
        in_sig = 5'b01010;
        #1 rst = 1'b0;
        #1 checkOutput("midstream_clear", mem_out, 16'h0000);
        @(posedge clk);
        #1 checkOutput("midstream_discard", mem_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        in_sig = 5'b00110;
        exp_q.push_back(relu_model(5'b00110));
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relu_func.md
RELU_FUNC -- requirements
Module: relu_func

Interface
REQ-001 The block SHALL have parameter IP_DATA_WIDTH, default 8: data width of the neuron datapath; output width is 2*IP_DATA_WIDTH.
REQ-002 The block SHALL have parameter MEM_WIDTH, default 5: width of the truncated MAC-sum slice at the input; the lookup table depth is 2**MEM_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in, input, MEM_WIDTH bits: signed two's-complement value, taken as the top MEM_WIDTH bits of the 2*IP_DATA_WIDTH-bit MAC sum.
REQ-006 The block SHALL have port mem_out, output, 2*IP_DATA_WIDTH bits: signed registered activation output.
REQ-007 Legality: MEM_WIDTH SHALL be at least 2 and at most 2*IP_DATA_WIDTH; the block SHALL report a violation as an elaboration-time error.

Function
REQ-008 The block SHALL contain an activation lookup table of 2**MEM_WIDTH entries, each 2*IP_DATA_WIDTH bits wide, indexed by in read as an unsigned address.
REQ-009 The table contents SHALL be computed at elaboration; no file load and no runtime write path.
REQ-010 Table entry at address a: let v be a interpreted as a signed MEM_WIDTH-bit value. The entry SHALL be 0 if v < 0.
REQ-011 Otherwise the entry SHALL be v shifted left by (2*IP_DATA_WIDTH - MEM_WIDTH), which restores the magnitude of the truncated sum.
REQ-012 Table entries for v >= 0 SHALL therefore have a zero MSB; the output SHALL never be negative and no saturation is needed.
REQ-013 Latency: on each rising clk edge with rst high, mem_out SHALL load table[in]; the result appears exactly 1 cycle after in is sampled.
REQ-014 Throughput: the block SHALL accept a new input every cycle, with no handshake and no stall.
REQ-015 mem_out SHALL be driven only by the output register; there SHALL be no combinational path from in to mem_out.
REQ-016 Boundary: in = 0 SHALL give 0.
REQ-017 Boundary: in = most-positive (0b0111..1) SHALL give (2**(MEM_WIDTH-1) - 1) << (2*IP_DATA_WIDTH - MEM_WIDTH).
REQ-018 Boundary: in = most-negative (0b1000..0) SHALL give 0.
REQ-019 X or Z values on in while rst is low SHALL have no effect on mem_out.

Reset
REQ-020 When rst goes low, mem_out SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-021 mem_out SHALL hold 0 for as long as rst is low.
REQ-022 After rst is released, the first rising clk edge SHALL load table[in] normally.
REQ-023 Reset asserted mid-stream SHALL discard any in-flight result; no stale value SHALL appear after release.
REQ-024 The table SHALL not be affected by reset.

Verification (IP_DATA_WIDTH=8, MEM_WIDTH=5, shift 11)
REQ-025 Positive value: in = 5'b00011 -> mem_out = 16'h1800 one clk edge later.
REQ-026 Saturation corner: in = 5'b01111 -> mem_out = 16'h7800. in = 5'b10000 -> 16'h0000. in = 5'b11111 -> 16'h0000.
REQ-027 Back-to-back stream: in = 1, 2, 0, 31 on consecutive cycles -> mem_out = 16'h0800, 16'h1000, 16'h0000, 16'h0000 on the following consecutive cycles.
REQ-028 Asynchronous reset: with mem_out = 16'h7800, drive rst low between clk edges -> mem_out = 0 before the next edge, and holds 0 while rst is low.
REQ-029 Reset release: rst high with in = 5'b00100 -> first edge gives mem_out = 16'h2000.
REQ-030 Exhaustive sweep: all 32 in codes -> mem_out matches REQ-010 and REQ-011, and changes only on rising clk edges.
